ysyx_25060170_muldiv_seq: RTL and testbench

Sequencer for the iterative Booth multiplier and the radix-2 divider inside the EXU.
- Accepts one M-extension operation at a time over a valid/ready handshake and launches exactly one start pulse to the correct unit.
- Waits for that unit's completion, then selects and sign-extends the result.
- Holds the result until the LSU side accepts it.
- Replaces the per-unit delay/stall flops in the EXU with one explicit FSM, and supports pipeline flush.

---
 rtl/ysyx_25060170_muldiv_pkg.sv | 73 +++++++
 rtl/ysyx_25060170_muldiv_seq.sv | 145 ++++++++++++++
 tb/tb_ysyx_25060170_muldiv_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060170_muldiv_pkg.sv
// Operation codes, sequencer states and decode helpers shared by the EXU
// multiply/divide sequencer.
package ysyx_25060170_muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_MULW   = 4'd4,
    OP_DIV    = 4'd5,
    OP_DIVU   = 4'd6,
    OP_REM    = 4'd7,
    OP_REMU   = 4'd8,
    OP_DIVW   = 4'd9,
    OP_DIVUW  = 4'd10,
    OP_REMW   = 4'd11,
    OP_REMUW  = 4'd12
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DONE     = 2'd3
  } md_state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return op <= 4'd4;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd12);
  endfunction

  function automatic logic is_w(input logic [3:0] op);
    case (op)
      OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic sel_hi(input logic [3:0] op);
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic sel_rem(input logic [3:0] op);
    case (op)
      OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // {op1 signed, op2 signed} as the Booth multiplier expects it
  function automatic logic [1:0] mul_sign(input logic [3:0] op);
    case (op)
      OP_MULHSU: return 2'b10;
      OP_MULHU:  return 2'b00;
      default:   return 2'b11;
    endcase
  endfunction

  function automatic logic div_is_signed(input logic [3:0] op);
    case (op)
      OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25060170_muldiv_seq.sv
// Single-outstanding sequencer for the EXU Booth multiplier and radix-2 divider:
// starts one unit, sign-extends its result and holds it for the LSU side.
module ysyx_25060170_muldiv_seq
  import ysyx_25060170_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [3:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_op1,
  input  logic [XLEN-1:0] i_req_op2,
  input  logic            i_flush,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_data,
  output logic            o_busy,
  output logic            o_mul_valid,
  output logic [1:0]      o_mul_signed,
  output logic            o_mulw,
  output logic [XLEN-1:0] o_mul_op1,
  output logic [XLEN-1:0] o_mul_op2,
  output logic            o_mul_flush,
  input  logic            i_mul_out_valid,
  input  logic [XLEN-1:0] i_mul_hi,
  input  logic [XLEN-1:0] i_mul_lo,
  output logic            o_div_valid,
  output logic            o_div_signed,
  output logic            o_divw,
  output logic [XLEN-1:0] o_div_op1,
  output logic [XLEN-1:0] o_div_op2,
  output logic            o_div_flush,
  input  logic            i_div_out_valid,
  input  logic [XLEN-1:0] i_quotient,
  input  logic [XLEN-1:0] i_remainder
);

  md_state_e       r_state;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_res;
  logic            r_start;

  logic w_live;
  logic w_mul_act;
  logic w_div_act;

  function automatic logic [XLEN-1:0] f_sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] f_result(
    input logic [3:0]      op,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] raw;
    if (is_mul(op)) raw = sel_hi(op) ? hi : lo;
    else            raw = sel_rem(op) ? r : q;
    return is_w(op) ? f_sext32(raw) : raw;
  endfunction

  // Everything the sequencer drives is forced low while rst is held.
  assign w_live    = ~rst;
  assign w_mul_act = w_live & (r_state == S_MUL_WAIT);
  assign w_div_act = w_live & (r_state == S_DIV_WAIT);

  assign o_req_ready  = w_live & ~i_flush & (r_state == S_IDLE);
  assign o_busy       = w_live & (r_state != S_IDLE);
  assign o_resp_valid = w_live & (r_state == S_DONE);
  assign o_resp_data  = o_resp_valid ? r_res : {XLEN{1'b0}};

  assign o_mul_valid  = w_mul_act & r_start;
  assign o_mul_signed = w_mul_act ? mul_sign(r_op) : 2'b00;
  assign o_mulw       = w_mul_act & is_w(r_op);
  assign o_mul_op1    = w_mul_act ? r_op1 : {XLEN{1'b0}};
  assign o_mul_op2    = w_mul_act ? r_op2 : {XLEN{1'b0}};
  assign o_mul_flush  = w_mul_act & i_flush;

  assign o_div_valid  = w_div_act & r_start;
  assign o_div_signed = w_div_act & div_is_signed(r_op);
  assign o_divw       = w_div_act & is_w(r_op);
  assign o_div_op1    = w_div_act ? r_op1 : {XLEN{1'b0}};
  assign o_div_op2    = w_div_act ? r_op2 : {XLEN{1'b0}};
  assign o_div_flush  = w_div_act & i_flush;

  // Sequencer FSM; flush outranks any completion or handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 4'd0;
      r_op1   <= {XLEN{1'b0}};
      r_op2   <= {XLEN{1'b0}};
      r_res   <= {XLEN{1'b0}};
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (i_flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_req_valid) begin
              r_op  <= i_req_op;
              r_op1 <= i_req_op1;
              r_op2 <= i_req_op2;
              if (is_mul(i_req_op)) begin
                r_state <= S_MUL_WAIT;
                r_start <= 1'b1;
              end else if (is_div(i_req_op)) begin
                r_state <= S_DIV_WAIT;
                r_start <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_res   <= {XLEN{1'b0}};
              end
            end
          end
          S_MUL_WAIT: begin
            if (i_mul_out_valid) begin
              r_res   <= f_result(r_op, i_mul_hi, i_mul_lo, i_quotient, i_remainder);
              r_state <= S_DONE;
            end
          end
          S_DIV_WAIT: begin
            if (i_div_out_valid) begin
              r_res   <= f_result(r_op, i_mul_hi, i_mul_lo, i_quotient, i_remainder);
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            if (i_resp_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_muldiv_seq.sv
// Directed bench for the muldiv sequencer with behavioural multiplier/divider
// models whose latency N is set per test.
module tb_ysyx_25060170_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_req_op;
  logic [63:0] i_req_op1;
  logic [63:0] i_req_op2;
  logic        i_flush;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [63:0] o_resp_data;
  logic        o_busy;
  logic        o_mul_valid;
  logic [1:0]  o_mul_signed;
  logic        o_mulw;
  logic [63:0] o_mul_op1;
  logic [63:0] o_mul_op2;
  logic        o_mul_flush;
  logic        i_mul_out_valid;
  logic [63:0] i_mul_hi;
  logic [63:0] i_mul_lo;
  logic        o_div_valid;
  logic        o_div_signed;
  logic        o_divw;
  logic [63:0] o_div_op1;
  logic [63:0] o_div_op2;
  logic        o_div_flush;
  logic        i_div_out_valid;
  logic [63:0] i_quotient;
  logic [63:0] i_remainder;

  int n_checks = 0;
  int n_fail   = 0;

  int          mul_n;
  int          div_n;
  int          mul_cnt;
  int          div_cnt;
  logic [127:0] mul_prod;
  logic [63:0]  div_q;
  logic [63:0]  div_r;

  int          lat;
  int          n_mpulse;
  int          n_dpulse;
  logic [1:0]  cap_msg;
  logic        cap_mw;
  logic        cap_ds;
  logic        cap_dw;
  logic [63:0] cap_op1;

  ysyx_25060170_muldiv_seq #(.XLEN(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_op        (i_req_op),
    .i_req_op1       (i_req_op1),
    .i_req_op2       (i_req_op2),
    .i_flush         (i_flush),
    .o_resp_valid    (o_resp_valid),
    .i_resp_ready    (i_resp_ready),
    .o_resp_data     (o_resp_data),
    .o_busy          (o_busy),
    .o_mul_valid     (o_mul_valid),
    .o_mul_signed    (o_mul_signed),
    .o_mulw          (o_mulw),
    .o_mul_op1       (o_mul_op1),
    .o_mul_op2       (o_mul_op2),
    .o_mul_flush     (o_mul_flush),
    .i_mul_out_valid (i_mul_out_valid),
    .i_mul_hi        (i_mul_hi),
    .i_mul_lo        (i_mul_lo),
    .o_div_valid     (o_div_valid),
    .o_div_signed    (o_div_signed),
    .o_divw          (o_divw),
    .o_div_op1       (o_div_op1),
    .o_div_op2       (o_div_op2),
    .o_div_flush     (o_div_flush),
    .i_div_out_valid (i_div_out_valid),
    .i_quotient      (i_quotient),
    .i_remainder     (i_remainder)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] f_prod(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] sg);
    logic [127:0] xa;
    logic [127:0] xb;
    xa = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
    xb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return xa * xb;
  endfunction

  function automatic logic [63:0] f_div(input logic [63:0] a, input logic [63:0] b,
                                        input logic sg, input logic w, input logic rem);
    logic [63:0] x;
    logic [63:0] y;
    if (w) begin
      x = sg ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      y = sg ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
    end else begin
      x = a;
      y = b;
    end
    if (y == 64'd0) return rem ? x : {64{1'b1}};
    if (sg) return rem ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
    return rem ? x % y : x / y;
  endfunction

  // Behavioural multiplier: done pulse N cycles after the start pulse, ignores flush.
  always @(posedge clk) begin
    i_mul_out_valid <= 1'b0;
    if (rst) begin
      mul_cnt <= 0;
    end else if (o_mul_valid) begin
      mul_prod <= f_prod(o_mul_op1, o_mul_op2, o_mul_signed);
      if (mul_n <= 1) i_mul_out_valid <= 1'b1;
      else mul_cnt <= mul_n - 1;
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
      if (mul_cnt == 1) i_mul_out_valid <= 1'b1;
    end
  end

  // Behavioural divider: same timing contract; keeps running after a flush.
  always @(posedge clk) begin
    i_div_out_valid <= 1'b0;
    if (rst) begin
      div_cnt <= 0;
    end else if (o_div_valid) begin
      div_q <= f_div(o_div_op1, o_div_op2, o_div_signed, o_divw, 1'b0);
      div_r <= f_div(o_div_op1, o_div_op2, o_div_signed, o_divw, 1'b1);
      if (div_n <= 1) i_div_out_valid <= 1'b1;
      else div_cnt <= div_n - 1;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) i_div_out_valid <= 1'b1;
    end
  end

  assign i_mul_hi    = mul_prod[127:64];
  assign i_mul_lo    = mul_prod[63:0];
  assign i_quotient  = div_q;
  assign i_remainder = div_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Offers one request; returns at #1 into the cycle after acceptance (T+1).
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_op1   = a;
    i_req_op2   = b;
    @(negedge clk);
    check("accept_ready", 64'(o_req_ready), 64'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  // Watches start pulses until resp_valid; lat is cycles after accept (0 = timeout).
  task automatic wait_resp();
    lat      = 0;
    n_mpulse = 0;
    n_dpulse = 0;
    cap_msg  = 2'b01;
    cap_mw   = 1'b0;
    cap_ds   = 1'b0;
    cap_dw   = 1'b0;
    cap_op1  = 64'd0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (o_mul_valid) begin
        n_mpulse++;
        cap_msg = o_mul_signed;
        cap_mw  = o_mulw;
        cap_op1 = o_mul_op1;
      end
      if (o_div_valid) begin
        n_dpulse++;
        cap_ds  = o_div_signed;
        cap_dw  = o_divw;
        cap_op1 = o_div_op1;
      end
      if (o_resp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Called at the negedge of a resp_valid cycle; completes the transfer.
  task automatic take_resp();
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_resp_ready = 1'b0;
    @(negedge clk);
    check("ready_after_xfer", 64'(o_req_ready), 64'd1);
    check("resp_drop_after_xfer", 64'(o_resp_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_resp;
    int seen;
    rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_op = 4'd0;
    i_req_op1 = 64'd0;
    i_req_op2 = 64'd0;
    i_flush = 1'b0;
    i_resp_ready = 1'b0;
    mul_n = 4;
    div_n = 4;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(o_req_ready), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(o_req_ready), 64'd1);
    check("post_rst_data", o_resp_data, 64'd0);

    // MUL 3 * -5, N=4
    issue(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    wait_resp();
    check("mul_lat", 64'(lat), 64'd6);
    check("mul_pulses", 64'(n_mpulse), 64'd1);
    check("mul_no_div", 64'(n_dpulse), 64'd0);
    check("mul_signed", 64'(cap_msg), 64'd3);
    check("mul_w", 64'(cap_mw), 64'd0);
    check("mul_op1", cap_op1, 64'd3);
    check("mul_data", o_resp_data, 64'hFFFF_FFFF_FFFF_FFF1);
    take_resp();

    // MULHU all-ones * 2 -> high half 1
    issue(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_resp();
    check("mulhu_signed", 64'(cap_msg), 64'd0);
    check("mulhu_data", o_resp_data, 64'd1);
    take_resp();

    // MULW 0x7FFFFFFF * 2 -> sext(0xFFFFFFFE)
    issue(4'd4, 64'h0000_0000_7FFF_FFFF, 64'd2);
    wait_resp();
    check("mulw_w", 64'(cap_mw), 64'd1);
    check("mulw_signed", 64'(cap_msg), 64'd3);
    check("mulw_data", o_resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
    take_resp();

    // DIVUW 0xFFFFFFFE / 1, N=3
    div_n = 3;
    issue(4'd10, 64'h0000_0000_FFFF_FFFE, 64'd1);
    wait_resp();
    check("divuw_lat", 64'(lat), 64'd5);
    check("divuw_pulses", 64'(n_dpulse), 64'd1);
    check("divuw_no_mul", 64'(n_mpulse), 64'd0);
    check("divuw_w", 64'(cap_dw), 64'd1);
    check("divuw_signed", 64'(cap_ds), 64'd0);
    check("divuw_data", o_resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
    take_resp();

    // REM -7 % 2 with the consumer stalled for five cycles
    issue(4'd7, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_resp();
    check("rem_signed", 64'(cap_ds), 64'd1);
    check("rem_w", 64'(cap_dw), 64'd0);
    check("rem_data", o_resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rem_hold_valid", 64'(o_resp_valid), 64'd1);
      check("rem_hold_data", o_resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
      check("rem_hold_noready", 64'(o_req_ready), 64'd0);
    end
    take_resp();

    // DIV with N=64, flushed in the 10th wait cycle alongside a competing request
    div_n = 64;
    issue(4'd5, 64'd100, 64'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    i_flush     = 1'b1;
    i_req_valid = 1'b1;
    i_req_op    = 4'd0;
    @(negedge clk);
    check("flush_div_pulse", 64'(o_div_flush), 64'd1);
    check("flush_no_mul_pulse", 64'(o_mul_flush), 64'd0);
    check("flush_req_ready", 64'(o_req_ready), 64'd0);
    @(posedge clk); #1;
    i_flush     = 1'b0;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("flush_pulse_end", 64'(o_div_flush), 64'd0);
    check("flush_idle", 64'(o_busy), 64'd0);
    check("flush_ready", 64'(o_req_ready), 64'd1);
    n_resp = 0;
    seen   = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_resp_valid) n_resp++;
      if (i_div_out_valid) seen++;
    end
    check("stale_div_seen", 64'(seen), 64'd1);
    check("stale_div_no_resp", 64'(n_resp), 64'd0);

    // MUL after the flush completes normally
    mul_n = 4;
    issue(4'd0, 64'd6, 64'd7);
    wait_resp();
    check("post_flush_lat", 64'(lat), 64'd6);
    check("post_flush_data", o_resp_data, 64'd42);
    take_resp();

    // Illegal op 14
    issue(4'd14, 64'd5, 64'd5);
    wait_resp();
    check("illegal_lat", 64'(lat), 64'd1);
    check("illegal_no_start", 64'(n_mpulse + n_dpulse), 64'd0);
    check("illegal_data", o_resp_data, 64'd0);
    take_resp();

    // rst asserted while the multiplier is running
    issue(4'd0, 64'd3, 64'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_no_flush", 64'(o_mul_flush), 64'd0);
    check("rst_mid_op1", o_mul_op1, 64'd0);
    check("rst_mid_ready", 64'(o_req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_busy", 64'(o_busy), 64'd0);
    check("rst_after_mul_valid", 64'(o_mul_valid), 64'd0);
    check("rst_after_resp", 64'(o_resp_valid), 64'd0);
    check("rst_after_ready", 64'(o_req_ready), 64'd1);
    n_resp = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_resp_valid) n_resp++;
    end
    check("rst_after_no_resp", 64'(n_resp), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
